// File: rtl/clkdiv_pkg.sv
// Shared types, limits and configuration clamping for the programmable clock divider.
package clkdiv_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int CLKDIV_MIN_DIV  = 2;
  localparam int CLKDIV_MIN_HIGH = 1;

  // Forces a requested period/high time into a shape that always toggles:
  // period of at least two cycles, high time at least one cycle and at least
  // one cycle shorter than the period. Result is {period, high}, 32 bits each.
  function automatic logic [63:0] clamp_cfg(input logic [31:0] div,
                                            input logic [31:0] high);
    logic [31:0] p;
    logic [31:0] h;
    p = (div < 32'(CLKDIV_MIN_DIV)) ? 32'(CLKDIV_MIN_DIV) : div;
    h = (high < 32'(CLKDIV_MIN_HIGH)) ? 32'(CLKDIV_MIN_HIGH) : high;
    if (h > p - 32'd1) h = p - 32'd1;
    return {p, h};
  endfunction

endpackage

// File: rtl/clkdiv_shadow.sv
// Configuration shadow register: accepts one clamped period/high-time pair,
// holds it as pending until the divider applies it at a safe point.
module clkdiv_shadow
  import clkdiv_pkg::*;
#(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_div,
  input  logic [W-1:0] cfg_high,
  input  logic         apply,
  output logic         cfg_ready,
  output logic         pending,
  output logic [W-1:0] shadow_div,
  output logic [W-1:0] shadow_high
);

  logic [63:0] clamped;

  assign clamped   = clamp_cfg(32'(cfg_div), 32'(cfg_high));
  assign cfg_ready = !pending;

  // Capture a clamped offer while the slot is free; release the slot once applied.
  // Accept and apply never coincide because accept requires pending to be clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending     <= 1'b0;
      shadow_div  <= '0;
      shadow_high <= '0;
    end else if (cfg_valid && cfg_ready) begin
      pending     <= 1'b1;
      shadow_div  <= W'(clamped[63:32]);
      shadow_high <= W'(clamped[31:0]);
    end else if (apply) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/prog_clock_divider.sv
// Runtime-programmable clock divider with glitch-free period-boundary updates.
// Optional macro CLKDIV_TICK_EN adds a one-cycle 'tick' strobe at each rising clk_out.
module prog_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int W        = 26,
  parameter int DEF_DIV  = 50000,
  parameter int DEF_HIGH = 25000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] cfg_div,
  input  logic [W-1:0] cfg_high,
  output logic         clk_out,
`ifdef CLKDIV_TICK_EN
  output logic         running,
  output logic         tick
`else
  output logic         running
`endif
);

  state_t       state, state_next;
  logic [W-1:0] cnt, cnt_next;
  logic [W-1:0] p_reg, p_next;
  logic [W-1:0] h_reg, h_next;
  logic         clk_out_next;
  logic         apply;
  logic         pending;
  logic [W-1:0] shadow_div;
  logic [W-1:0] shadow_high;
  logic         at_boundary;

  clkdiv_shadow #(.W(W)) u_shadow (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_div    (cfg_div),
    .cfg_high   (cfg_high),
    .apply      (apply),
    .cfg_ready  (cfg_ready),
    .pending    (pending),
    .shadow_div (shadow_div),
    .shadow_high(shadow_high)
  );

  assign at_boundary = (cnt == p_reg - W'(1));
  assign running     = (state == RUN);

  // Next state, counter and active period/high time; new settings are only
  // taken in IDLE or on the last cycle of a period, so clk_out never glitches.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    p_next     = p_reg;
    h_next     = h_reg;
    apply      = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (pending) begin
          apply  = 1'b1;
          p_next = shadow_div;
          h_next = shadow_high;
        end
        if (en) state_next = RUN;
      end
      RUN: begin
        if (at_boundary) begin
          cnt_next = '0;
          if (pending) begin
            apply  = 1'b1;
            p_next = shadow_div;
            h_next = shadow_high;
          end
          if (!en) state_next = IDLE;
        end else begin
          cnt_next = cnt + W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
    clk_out_next = (state_next == RUN) && (cnt_next < h_next);
  end

  // State, counter, active settings and the registered divided clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      p_reg   <= W'(DEF_DIV);
      h_reg   <= W'(DEF_HIGH);
      clk_out <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      p_reg   <= p_next;
      h_reg   <= h_next;
      clk_out <= clk_out_next;
    end
  end

`ifdef CLKDIV_TICK_EN
  // One-cycle strobe on the first cycle of every running period.
  always_ff @(posedge clk) begin
    if (rst) tick <= 1'b0;
    else     tick <= (state_next == RUN) && (cnt_next == '0);
  end
`endif

endmodule

// File: tb/tb_prog_clock_divider.sv
// Self-checking bench for prog_clock_divider: directed scenarios followed by
// randomized traffic, compared each cycle against a period-position model.
module tb_prog_clock_divider;

  localparam int W        = 8;
  localparam int DEF_DIV  = 10;
  localparam int DEF_HIGH = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic [W-1:0] cfg_high;
  logic         cfg_ready;
  logic         clk_out;
  logic         running;
`ifdef CLKDIV_TICK_EN
  logic         tick;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: whether a divided clock is running, the position within
  // the current period, the active period/high time and a one-entry offer slot.
  bit m_run;
  int m_pos;
  int m_p;
  int m_h;
  bit m_pend;
  int m_sp;
  int m_sh;
  bit m_accepted;

  prog_clock_divider #(.W(W), .DEF_DIV(DEF_DIV), .DEF_HIGH(DEF_HIGH)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_div  (cfg_div),
    .cfg_high (cfg_high),
    .clk_out  (clk_out),
`ifdef CLKDIV_TICK_EN
    .running  (running),
    .tick     (tick)
`else
    .running  (running)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs presented to the DUT.
  task automatic modelEdge();
    bit was_pend;
    was_pend   = m_pend;
    m_accepted = 1'b0;
    if (rst) begin
      m_run = 0; m_pos = 0; m_p = DEF_DIV; m_h = DEF_HIGH; m_pend = 0;
    end else begin
      if (!m_run) begin
        if (was_pend) begin m_p = m_sp; m_h = m_sh; m_pend = 0; end
        if (en) begin m_run = 1; m_pos = 0; end
      end else if (m_pos == m_p - 1) begin
        if (was_pend) begin m_p = m_sp; m_h = m_sh; m_pend = 0; end
        m_pos = 0;
        if (!en) m_run = 0;
      end else begin
        m_pos++;
      end
      if (cfg_valid && !was_pend) begin
        m_sp = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
        m_sh = (int'(cfg_high) < 1) ? 1 : int'(cfg_high);
        if (m_sh > m_sp - 1) m_sh = m_sp - 1;
        m_pend     = 1;
        m_accepted = 1'b1;
      end
    end
  endtask

  // One clock: update the model on the edge, then compare just after it.
  task automatic applyStimulus();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("clk_out", clk_out, m_run && (m_pos < m_h));
    checkOutput("running", running, m_run);
    checkOutput("cfg_ready", cfg_ready, !m_pend);
`ifdef CLKDIV_TICK_EN
    checkOutput("tick", tick, m_run && (m_pos == 0));
`endif
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  // Hold an offer until the slot accepts it, within a bounded number of cycles.
  task automatic offer(input int d, input int h);
    int budget;
    cfg_valid = 1'b1;
    cfg_div   = W'(d);
    cfg_high  = W'(h);
    budget    = 0;
    do begin
      applyStimulus();
      budget++;
    end while (!m_accepted && budget < 300);
    checks++;
    if (!m_accepted) begin
      failures++;
      $display("[TB] FAIL offer_accept observed=timeout expected=accepted");
    end
    cfg_valid = 1'b0;
  endtask

  task automatic runUntilPos(input int pos);
    int budget;
    budget = 0;
    while (!(m_run && m_pos == pos) && budget < 300) begin
      applyStimulus();
      budget++;
    end
    checks++;
    if (!(m_run && m_pos == pos)) begin
      failures++;
      $display("[TB] FAIL reach_pos observed=timeout expected=pos%0d", pos);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0; cfg_high = '0;
    m_run = 0; m_pos = 0; m_p = DEF_DIV; m_h = DEF_HIGH; m_pend = 0;
    m_sp = 0; m_sh = 0; m_accepted = 0;

    runCycles(2);
    rst = 1'b0;
    runCycles(3);

    // Default 5/5 divide-by-10, first high one cycle after enable.
    en = 1'b1;
    runCycles(25);

    // Mid-period load of 4/1, then a second offer stalled until the boundary.
    runUntilPos(3);
    cfg_valid = 1'b1; cfg_div = 8'd4; cfg_high = 8'd1;
    applyStimulus();
    cfg_valid = 1'b0;
    offer(1, 0);
    runCycles(20);
    offer(7, 9);
    runCycles(25);
    offer(10, 5);
    runCycles(25);

    // Stop mid-period, then re-enable.
    runUntilPos(2);
    en = 1'b0;
    runCycles(12);
    en = 1'b1;
    runCycles(5);

    // Reset mid-run with a pending configuration.
    offer(3, 1);
    runCycles(10);
    runUntilPos(1);
    cfg_valid = 1'b1; cfg_div = 8'd20; cfg_high = 8'd3;
    applyStimulus();
    cfg_valid = 1'b0;
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    runCycles(25);

    // Randomized traffic: enables, offers with extreme values, occasional resets.
    for (int i = 0; i < 2500; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) en = ~en;
      if (!cfg_valid && $urandom_range(0, 24) == 0) begin
        cfg_valid = 1'b1;
        if ($urandom_range(0, 7) == 0) begin
          cfg_div  = W'($urandom);
          cfg_high = W'($urandom);
        end else begin
          cfg_div  = W'($urandom_range(0, 12));
          cfg_high = W'($urandom_range(0, 12));
        end
      end
      applyStimulus();
      if (m_accepted) cfg_valid = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
